// File: rtl/sfpga_cfg_pkg.sv
// Shared definitions for the slave SelectMAP x16 receiver: FSM encoding,
// sync/dummy word constants and the per-byte bit unswap.
package sfpga_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SYNC  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_START = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } rx_state_e;

  localparam logic [15:0] SYNC_W0 = 16'h00BB;
  localparam logic [15:0] SYNC_W1 = 16'h0022;
  localparam logic [15:0] SYNC_W2 = 16'h5566;
  localparam logic [15:0] DUMMY_W = 16'hFFFF;

  // The master reverses the bits of each byte on the bus; undo that when en=1.
  function automatic logic [15:0] unswap(input logic [15:0] w, input logic en);
    logic [15:0] r;
    r = w;
    if (en) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 8; i++) begin
          r[8*b+i] = w[8*b+7-i];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sfpga_sync_detect.sv
// Three-word sync sequence matcher; emits a registered one-cycle sync_hit
// the cycle after the final sync word is seen.
module sfpga_sync_detect
  import sfpga_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] word,
  input  logic        wr,
  input  logic        clr,
  output logic        sync_hit
);

  logic [1:0] step;
  logic [1:0] step_next;
  logic       hit_next;

  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    step_next = step;
    hit_next  = 1'b0;
    if (clr) begin
      step_next = 2'd0;
    end else if (wr) begin
      if (word == DUMMY_W) begin
        step_next = step;
      end else if (step == 2'd2 && word == SYNC_W2) begin
        step_next = 2'd0;
        hit_next  = 1'b1;
      end else if (step == 2'd1 && word == SYNC_W1) begin
        step_next = 2'd2;
      end else if (word == SYNC_W0) begin
        // A stray first sync word restarts the match rather than killing it.
        step_next = 2'd1;
      end else begin
        step_next = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step     <= 2'd0;
      sync_hit <= 1'b0;
    end else begin
      step     <= step_next;
      sync_hit <= hit_next;
    end
  end

endmodule

// File: rtl/sfpga_selectmap_rx.sv
// Slave-side SelectMAP x16 receiver: INIT_B handshake, sync detection,
// payload unswap/count/forward and DONE emulation.
module sfpga_selectmap_rx
  import sfpga_cfg_pkg::*;
#(
  parameter int INIT_LOW_CYC = 16,
  parameter int DONE_DLY     = 8,
  parameter int LEN_W        = 32,
  parameter bit BIT_SWAP     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LEN_W-1:0] cfg_len_words_i,
  input  logic             prog_b_i,
  input  logic             csi_b_i,
  input  logic             rdwr_b_i,
  input  logic [15:0]      cfg_d_i,
  output logic             init_b_o,
  output logic             done_o,
  output logic [15:0]      rx_data_o,
  output logic             rx_vld_o,
  output logic [LEN_W-1:0] rx_cnt_o,
  output logic             sync_ok_o,
  output logic             err_o
);

  localparam int TMR_MAX = (INIT_LOW_CYC > DONE_DLY) ? INIT_LOW_CYC : DONE_DLY;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] INIT_END = TMR_W'(INIT_LOW_CYC - 1);
  localparam logic [TMR_W-1:0] DLY_END  = TMR_W'(DONE_DLY - 1);

  rx_state_e        state;
  rx_state_e        state_next;
  logic             prog_b_q;
  logic             csi_b_q;
  logic             rdwr_b_q;
  logic [15:0]      d_q;
  logic [TMR_W-1:0] tmr;
  logic [LEN_W-1:0] cnt_inc;
  logic [15:0]      word;
  logic             wr;
  logic             rd;
  logic             sync_hit;

  // Master launches on negedge; everything downstream uses these copies.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prog_b_q <= 1'b1;
      csi_b_q  <= 1'b1;
      rdwr_b_q <= 1'b1;
      d_q      <= 16'h0000;
    end else begin
      prog_b_q <= prog_b_i;
      csi_b_q  <= csi_b_i;
      rdwr_b_q <= rdwr_b_i;
      d_q      <= cfg_d_i;
    end
  end

  assign wr      = !csi_b_q && !rdwr_b_q;
  assign rd      = !csi_b_q && rdwr_b_q;
  assign word    = unswap(d_q, BIT_SWAP);
  assign cnt_inc = (&rx_cnt_o) ? rx_cnt_o : rx_cnt_o + LEN_W'(1);

  sfpga_sync_detect u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .word     (word),
    .wr       (wr && state == ST_SYNC),
    .clr      (state != ST_SYNC || !prog_b_q),
    .sync_hit (sync_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!prog_b_q) begin
      state_next = ST_CLEAR;
    end else begin
      unique case (state)
        ST_IDLE:  state_next = ST_IDLE;
        ST_CLEAR: if (tmr == INIT_END) state_next = ST_SYNC;
        ST_SYNC: begin
          if (rd)            state_next = ST_ERR;
          else if (sync_hit) state_next = (cfg_len_words_i == '0) ? ST_START : ST_LOAD;
        end
        ST_LOAD: begin
          if (rd)                                   state_next = ST_ERR;
          else if (wr && cnt_inc >= cfg_len_words_i) state_next = ST_START;
        end
        ST_START: begin
          if (rd)                  state_next = ST_ERR;
          else if (tmr == DLY_END) state_next = ST_DONE;
        end
        ST_DONE:  state_next = ST_DONE;
        ST_ERR:   state_next = ST_ERR;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    init_b_o = !(state == ST_CLEAR || state == ST_ERR);
    done_o   = (state == ST_DONE);
    err_o    = (state == ST_ERR);
  end

  // One timer serves both the INIT_B low window and the startup delay.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (!prog_b_q || state_next != state) begin
      tmr <= '0;
    end else if (state == ST_CLEAR || state == ST_START) begin
      tmr <= tmr + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data_o <= 16'h0000;
      rx_vld_o  <= 1'b0;
      rx_cnt_o  <= '0;
      sync_ok_o <= 1'b0;
    end else begin
      rx_vld_o <= 1'b0;
      if (!prog_b_q) begin
        rx_cnt_o  <= '0;
        sync_ok_o <= 1'b0;
      end else begin
        if (state == ST_SYNC && (state_next == ST_LOAD || state_next == ST_START)) begin
          sync_ok_o <= 1'b1;
        end
        if (state == ST_LOAD && wr) begin
          rx_vld_o  <= 1'b1;
          rx_data_o <= word;
          rx_cnt_o  <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_sfpga_selectmap_rx.sv
// Directed bench for sfpga_selectmap_rx: init handshake, sync search, payload
// forwarding, DONE timing, readback error, PROG_B abort and reset abort.
module tb_sfpga_selectmap_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cfg_len;
  logic        prog_b;
  logic        csi_b;
  logic        rdwr_b;
  logic [15:0] cfg_d;
  logic        init_b;
  logic        done;
  logic [15:0] rx_data;
  logic        rx_vld;
  logic [31:0] rx_cnt;
  logic        sync_ok;
  logic        err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Bus values are bit-reversed per byte; exp_* are the unswapped words.
  logic [15:0] pay_bus [4] = '{16'h5599, 16'h482C, 16'h0000, 16'hFFFF};
  logic [15:0] pay_exp [4] = '{16'hAA99, 16'h1234, 16'h0000, 16'hFFFF};

  always #5 clk = ~clk;

  sfpga_selectmap_rx dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_len_words_i (cfg_len),
    .prog_b_i        (prog_b),
    .csi_b_i         (csi_b),
    .rdwr_b_i        (rdwr_b),
    .cfg_d_i         (cfg_d),
    .init_b_o        (init_b),
    .done_o          (done),
    .rx_data_o       (rx_data),
    .rx_vld_o        (rx_vld),
    .rx_cnt_o        (rx_cnt),
    .sync_ok_o       (sync_ok),
    .err_o           (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    csi_b  = 1'b1;
    rdwr_b = 1'b1;
    cfg_d  = 16'h0000;
  endtask

  task automatic wr(input logic [15:0] w);
    csi_b  = 1'b0;
    rdwr_b = 1'b0;
    cfg_d  = w;
    step();
    bus_idle();
  endtask

  task automatic do_init();
    prog_b = 1'b0;
    repeat (3) step();
    prog_b = 1'b1;
    repeat (17) step();
  endtask

  task automatic do_sync();
    wr(16'h00DD);
    wr(16'h0044);
    wr(16'hAA66);
    wr(16'hFFFF);
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    total_cnt++; if (init_b !== 1'b1)   $display("FAIL rst_init_b: got %b want 1", init_b); else pass_cnt++;
    total_cnt++; if (done !== 1'b0)     $display("FAIL rst_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (rx_vld !== 1'b0)   $display("FAIL rst_vld: got %b want 0", rx_vld); else pass_cnt++;
    total_cnt++; if (rx_cnt !== 32'd0)  $display("FAIL rst_cnt: got %0d want 0", rx_cnt); else pass_cnt++;
    total_cnt++; if (rx_data !== 16'h0) $display("FAIL rst_data: got %h want 0000", rx_data); else pass_cnt++;
    total_cnt++; if (sync_ok !== 1'b0)  $display("FAIL rst_sync_ok: got %b want 0", sync_ok); else pass_cnt++;
    total_cnt++; if (err !== 1'b0)      $display("FAIL rst_err: got %b want 0", err); else pass_cnt++;
  endtask

  task automatic test_init();
    prog_b = 1'b0;
    step();
    total_cnt++; if (init_b !== 1'b1) $display("FAIL init_clk1: got %b want 1", init_b); else pass_cnt++;
    step();
    total_cnt++; if (init_b !== 1'b0) $display("FAIL init_clk2: got %b want 0", init_b); else pass_cnt++;
    repeat (3) step();
    prog_b = 1'b1;
    repeat (16) step();
    total_cnt++; if (init_b !== 1'b0) $display("FAIL init_hold16: got %b want 0", init_b); else pass_cnt++;
    step();
    total_cnt++; if (init_b !== 1'b1) $display("FAIL init_rise: got %b want 1", init_b); else pass_cnt++;
  endtask

  task automatic test_sync_load();
    wr(16'hFFFF);
    wr(16'h00DD);
    wr(16'h0044);
    wr(16'hAA66);
    wr(16'hFFFF);
    total_cnt++; if (sync_ok !== 1'b0) $display("FAIL sync_early: got %b want 0", sync_ok); else pass_cnt++;
    step();
    total_cnt++; if (sync_ok !== 1'b1) $display("FAIL sync_ok: got %b want 1", sync_ok); else pass_cnt++;
    total_cnt++; if (rx_vld !== 1'b0)  $display("FAIL sync_no_vld: got %b want 0", rx_vld); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      wr(pay_bus[i]);
      total_cnt++; if (rx_vld !== 1'b0) $display("FAIL load_vld_early[%0d]: got %b want 0", i, rx_vld); else pass_cnt++;
      step();
      total_cnt++; if (rx_vld !== 1'b1) $display("FAIL load_vld[%0d]: got %b want 1", i, rx_vld); else pass_cnt++;
      total_cnt++; if (rx_data !== pay_exp[i]) $display("FAIL load_data[%0d]: got %h want %h", i, rx_data, pay_exp[i]); else pass_cnt++;
      total_cnt++; if (rx_cnt !== 32'(i + 1)) $display("FAIL load_cnt[%0d]: got %0d want %0d", i, rx_cnt, i + 1); else pass_cnt++;
    end
    step();
    total_cnt++; if (rx_vld !== 1'b0) $display("FAIL load_vld_pulse: got %b want 0", rx_vld); else pass_cnt++;
    repeat (6) step();
    total_cnt++; if (done !== 1'b0) $display("FAIL done_early: got %b want 0", done); else pass_cnt++;
    step();
    total_cnt++; if (done !== 1'b1) $display("FAIL done_at8: got %b want 1", done); else pass_cnt++;
    wr(16'h482C);
    step();
    total_cnt++; if (rx_vld !== 1'b0)  $display("FAIL done_ignore_vld: got %b want 0", rx_vld); else pass_cnt++;
    total_cnt++; if (rx_cnt !== 32'd4) $display("FAIL done_cnt: got %0d want 4", rx_cnt); else pass_cnt++;
    total_cnt++; if (done !== 1'b1)    $display("FAIL done_hold: got %b want 1", done); else pass_cnt++;
  endtask

  task automatic test_resync();
    do_init();
    wr(16'h00DD);
    wr(16'h0044);
    wr(16'h8888);
    wr(16'hAA66);
    repeat (3) step();
    total_cnt++; if (sync_ok !== 1'b0) $display("FAIL resync_broken: got %b want 0", sync_ok); else pass_cnt++;
    wr(16'h00DD);
    wr(16'h0044);
    wr(16'h8888);
    wr(16'h00DD);
    wr(16'h0044);
    step();
    total_cnt++; if (sync_ok !== 1'b0) $display("FAIL resync_at_1111: got %b want 0", sync_ok); else pass_cnt++;
    wr(16'hAA66);
    step();
    total_cnt++; if (sync_ok !== 1'b0) $display("FAIL resync_early: got %b want 0", sync_ok); else pass_cnt++;
    total_cnt++; if (rx_vld !== 1'b0)  $display("FAIL resync_no_vld: got %b want 0", rx_vld); else pass_cnt++;
    step();
    total_cnt++; if (sync_ok !== 1'b1) $display("FAIL resync_ok: got %b want 1", sync_ok); else pass_cnt++;
  endtask

  task automatic test_error();
    wr(pay_bus[0]);
    step();
    total_cnt++; if (rx_cnt !== 32'd1) $display("FAIL err_pre_cnt: got %0d want 1", rx_cnt); else pass_cnt++;
    csi_b  = 1'b0;
    rdwr_b = 1'b1;
    step();
    bus_idle();
    total_cnt++; if (err !== 1'b0)    $display("FAIL err_clk1: got %b want 0", err); else pass_cnt++;
    step();
    total_cnt++; if (err !== 1'b1)    $display("FAIL err_set: got %b want 1", err); else pass_cnt++;
    total_cnt++; if (init_b !== 1'b0) $display("FAIL err_init_b: got %b want 0", init_b); else pass_cnt++;
    wr(pay_bus[1]);
    wr(pay_bus[2]);
    wr(pay_bus[3]);
    repeat (12) step();
    total_cnt++; if (done !== 1'b0) $display("FAIL err_no_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (err !== 1'b1)  $display("FAIL err_sticky: got %b want 1", err); else pass_cnt++;
    prog_b = 1'b0;
    repeat (2) step();
    total_cnt++; if (err !== 1'b0)     $display("FAIL err_clear: got %b want 0", err); else pass_cnt++;
    total_cnt++; if (rx_cnt !== 32'd0) $display("FAIL err_cnt_clear: got %0d want 0", rx_cnt); else pass_cnt++;
    step();
    prog_b = 1'b1;
    repeat (17) step();
  endtask

  task automatic test_prog_midload();
    do_sync();
    wr(pay_bus[0]);
    wr(pay_bus[1]);
    step();
    total_cnt++; if (rx_cnt !== 32'd2) $display("FAIL mid_cnt2: got %0d want 2", rx_cnt); else pass_cnt++;
    prog_b = 1'b0;
    repeat (2) step();
    total_cnt++; if (rx_cnt !== 32'd0)  $display("FAIL mid_cnt_clear: got %0d want 0", rx_cnt); else pass_cnt++;
    total_cnt++; if (sync_ok !== 1'b0)  $display("FAIL mid_sync_clear: got %b want 0", sync_ok); else pass_cnt++;
    total_cnt++; if (init_b !== 1'b0)   $display("FAIL mid_init_low: got %b want 0", init_b); else pass_cnt++;
    step();
    prog_b = 1'b1;
    repeat (16) step();
    total_cnt++; if (init_b !== 1'b0)   $display("FAIL mid_init_hold: got %b want 0", init_b); else pass_cnt++;
    step();
    total_cnt++; if (init_b !== 1'b1)   $display("FAIL mid_init_rise: got %b want 1", init_b); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_sync();
    total_cnt++; if (sync_ok !== 1'b1) $display("FAIL b2b_sync: got %b want 1", sync_ok); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        csi_b  = 1'b0;
        rdwr_b = 1'b0;
        cfg_d  = pay_bus[i];
      end else begin
        bus_idle();
      end
      step();
      if (i == 0) begin
        total_cnt++; if (rx_vld !== 1'b0) $display("FAIL b2b_vld_early: got %b want 0", rx_vld); else pass_cnt++;
      end else begin
        total_cnt++; if (rx_vld !== 1'b1) $display("FAIL b2b_vld[%0d]: got %b want 1", i - 1, rx_vld); else pass_cnt++;
        total_cnt++; if (rx_data !== pay_exp[i-1]) $display("FAIL b2b_data[%0d]: got %h want %h", i - 1, rx_data, pay_exp[i-1]); else pass_cnt++;
        total_cnt++; if (rx_cnt !== 32'(i)) $display("FAIL b2b_cnt[%0d]: got %0d want %0d", i - 1, rx_cnt, i); else pass_cnt++;
      end
    end
    repeat (7) step();
    total_cnt++; if (done !== 1'b0) $display("FAIL b2b_done_early: got %b want 0", done); else pass_cnt++;
    step();
    total_cnt++; if (done !== 1'b1) $display("FAIL b2b_done: got %b want 1", done); else pass_cnt++;
  endtask

  task automatic test_reset_midload();
    do_init();
    do_sync();
    wr(pay_bus[0]);
    csi_b  = 1'b0;
    rdwr_b = 1'b0;
    cfg_d  = pay_bus[1];
    rst_n  = 1'b0;
    step();
    rst_n = 1'b1;
    total_cnt++; if (rx_vld !== 1'b0)  $display("FAIL rml_vld: got %b want 0", rx_vld); else pass_cnt++;
    total_cnt++; if (rx_cnt !== 32'd0) $display("FAIL rml_cnt: got %0d want 0", rx_cnt); else pass_cnt++;
    total_cnt++; if (rx_data !== 16'h0) $display("FAIL rml_data: got %h want 0000", rx_data); else pass_cnt++;
    total_cnt++; if (sync_ok !== 1'b0) $display("FAIL rml_sync_ok: got %b want 0", sync_ok); else pass_cnt++;
    total_cnt++; if (init_b !== 1'b1)  $display("FAIL rml_init_b: got %b want 1", init_b); else pass_cnt++;
    wr(pay_bus[2]);
    wr(pay_bus[3]);
    repeat (3) step();
    total_cnt++; if (rx_cnt !== 32'd0) $display("FAIL rml_idle_cnt: got %0d want 0", rx_cnt); else pass_cnt++;
    total_cnt++; if (init_b !== 1'b1)  $display("FAIL rml_idle_init_b: got %b want 1", init_b); else pass_cnt++;
    total_cnt++; if (done !== 1'b0)    $display("FAIL rml_idle_done: got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_len_zero();
    cfg_len = 32'd0;
    do_init();
    do_sync();
    total_cnt++; if (sync_ok !== 1'b1) $display("FAIL len0_sync: got %b want 1", sync_ok); else pass_cnt++;
    repeat (7) step();
    total_cnt++; if (done !== 1'b0) $display("FAIL len0_done_early: got %b want 0", done); else pass_cnt++;
    step();
    total_cnt++; if (done !== 1'b1)    $display("FAIL len0_done: got %b want 1", done); else pass_cnt++;
    total_cnt++; if (rx_cnt !== 32'd0) $display("FAIL len0_cnt: got %0d want 0", rx_cnt); else pass_cnt++;
  endtask

  initial begin
    rst_n   = 1'b0;
    cfg_len = 32'd4;
    prog_b  = 1'b1;
    bus_idle();
    test_reset();
    test_init();
    test_sync_load();
    test_resync();
    test_error();
    test_prog_midload();
    test_back_to_back();
    test_reset_midload();
    test_len_zero();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
